// File: rtl/bcd_freq_gen.sv
// bcd_freq_gen -- programmable square-wave generator.
//
// Takes a target frequency in Hz as packed BCD digits (MS digit in the top
// nibble), converts it to binary, divides CLK_HZ by twice that value to get
// the half-period in clock cycles, and toggles fout at that rate.
//
// Ports:
//   clk       system clock running at CLK_HZ
//   res_n     asynchronous active-low reset
//   bcd_in    target frequency, packed BCD, DIGITS digits
//   load      1-cycle strobe: sample bcd_in and start reprogramming
//   en        output enable; 0 forces fout=0 and clears the period counter
//   busy      conversion/division in progress
//   done      1-cycle pulse: new setting applied
//   err       last load rejected (sticky until the next applied setting)
//   freq_bin  binary value of the active frequency setting
//   fout      generated square wave
module bcd_freq_gen #(
   parameter int unsigned CLK_HZ = 40_000_000,
   parameter int unsigned DIGITS = 8,
   parameter int unsigned DIV_W  = 32
) (
   input  logic                  clk,
   input  logic                  res_n,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic                  load,
   input  logic                  en,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [26:0]           freq_bin,
   output logic                  fout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_CHECK,
      S_DIV,
      S_APPLY
   } state_t;

   localparam int unsigned       STEP_W    = $clog2(DIV_W + DIGITS + 1);
   localparam logic [DIV_W-1:0]  CLK_V     = DIV_W'(CLK_HZ);
   localparam logic [DIV_W-1:0]  HALF_CLK  = DIV_W'(CLK_HZ / 2);
   localparam logic [STEP_W-1:0] CONV_LAST = STEP_W'(DIGITS - 1);
   localparam logic [STEP_W-1:0] DIV_LAST  = STEP_W'(DIV_W - 1);

   state_t                state;
   state_t                state_nxt;

   logic [4*DIGITS-1:0]   shreg;
   logic [26:0]           acc;
   logic [STEP_W-1:0]     step;
   logic [DIV_W:0]        rem;
   logic [DIV_W-1:0]      quo;
   logic [DIV_W-1:0]      divisor;
   logic [DIV_W-1:0]      half_active;
   logic [DIV_W-1:0]      cnt;

   logic [3:0]            digit;
   logic                  digit_bad;
   logic [26:0]           acc_mac;
   logic                  too_big;
   logic [DIV_W+1:0]      rem_sh;
   logic [DIV_W:0]        rem_sub;
   logic                  fits;

   // ------------------------------------------------------------------
   // Datapath combinational helpers
   // ------------------------------------------------------------------
   always_comb begin
      digit     = shreg[4*DIGITS-1 -: 4];
      digit_bad = (digit > 4'd9);
      acc_mac   = (acc << 3) + (acc << 1) + 27'(digit);
      too_big   = (DIV_W'(acc) > HALF_CLK);
      // Restoring step: shift the next dividend bit into the remainder.
      // The extra top bit keeps the compare exact; after a subtraction the
      // remainder is below the divisor, so it always fits in DIV_W+1 bits.
      rem_sh    = {rem, quo[DIV_W-1]};
      fits      = (rem_sh >= (DIV_W+2)'(divisor));
      rem_sub   = rem_sh[DIV_W:0] - (DIV_W+1)'(divisor);
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (load) state_nxt = S_CONV;
         S_CONV: begin
            if (digit_bad)              state_nxt = S_IDLE;
            else if (step == CONV_LAST) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (too_big)         state_nxt = S_IDLE;
            else if (acc == '0)  state_nxt = S_APPLY;
            else                 state_nxt = S_DIV;
         end
         S_DIV:   if (step == DIV_LAST) state_nxt = S_APPLY;
         S_APPLY: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Conversion / division datapath and status outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         freq_bin    <= '0;
         shreg       <= '0;
         acc         <= '0;
         step        <= '0;
         rem         <= '0;
         quo         <= '0;
         divisor     <= '0;
         half_active <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load) begin
                  shreg <= bcd_in;
                  acc   <= '0;
                  step  <= '0;
                  busy  <= 1'b1;
               end
            end
            S_CONV: begin
               if (digit_bad) begin
                  err  <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  acc   <= acc_mac;
                  shreg <= shreg << 4;
                  step  <= (step == CONV_LAST) ? '0 : step + STEP_W'(1);
               end
            end
            S_CHECK: begin
               if (too_big) begin
                  err  <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  divisor <= DIV_W'({acc, 1'b0});
                  rem     <= '0;
                  quo     <= CLK_V;
                  step    <= '0;
               end
            end
            S_DIV: begin
               rem  <= fits ? rem_sub : rem_sh[DIV_W:0];
               quo  <= {quo[DIV_W-2:0], fits};
               step <= step + STEP_W'(1);
            end
            S_APPLY: begin
               // A zero setting skipped the divider, so quo is stale there.
               half_active <= (acc == '0) ? '0 : quo;
               freq_bin    <= acc;
               err         <= 1'b0;
               done        <= 1'b1;
               busy        <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Square-wave generator; APPLY restarts the phase
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         cnt  <= '0;
         fout <= 1'b0;
      end else if (state == S_APPLY || !en || half_active == '0) begin
         cnt  <= '0;
         fout <= 1'b0;
      end else if (cnt == half_active - DIV_W'(1)) begin
         cnt  <= '0;
         fout <= ~fout;
      end else begin
         cnt  <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: tb/tb_bcd_freq_gen.sv
// tb_bcd_freq_gen -- directed self-checking bench for bcd_freq_gen
// (CLK_HZ=40e6, DIGITS=8, DIV_W=32).
//
// Timing convention: the load strobe is captured at edge T0; outputs are
// sampled 1 time unit after each following edge, k counting edges after T0.
// A value "high at T0+n" in pre-edge terms is therefore seen here at k=n-1.
module tb_bcd_freq_gen;

   logic        clk;
   logic        res_n;
   logic [31:0] bcd_in;
   logic        load;
   logic        en;
   logic        busy;
   logic        done;
   logic        err;
   logic [26:0] freq_bin;
   logic        fout;

   int tests;
   int fails;
   int cyc;
   int a_cyc;

   bcd_freq_gen #(
      .CLK_HZ (40_000_000),
      .DIGITS (8),
      .DIV_W  (32)
   ) dut (
      .clk      (clk),
      .res_n    (res_n),
      .bcd_in   (bcd_in),
      .load     (load),
      .en       (en),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .freq_bin (freq_bin),
      .fout     (fout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe load for one edge, then follow until busy drops (bounded).
   task automatic run_load(input logic [31:0] v, output int end_k, output int done_k);
      int k;
      @(negedge clk);
      bcd_in = v;
      load   = 1'b1;
      @(posedge clk);
      #1;
      load   = 1'b0;
      k      = 0;
      end_k  = -1;
      done_k = -1;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_start: got %b expected 1", busy);
      end
      while (k < 200) begin
         @(posedge clk);
         #1;
         k++;
         if (done === 1'b1 && done_k < 0) done_k = k;
         if (busy === 1'b0) begin
            end_k = k;
            break;
         end
      end
      a_cyc = cyc;
   endtask

   task automatic test_reset();
      res_n  = 1'b0;
      load   = 1'b0;
      en     = 1'b0;
      bcd_in = '0;
      #12;
      tests++;
      if ({busy, done, err, fout} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, fout});
      end
      tests++;
      if (freq_bin !== 27'd0) begin
         fails++;
         $display("FAIL reset_freq: got %0d expected 0", freq_bin);
      end
      @(negedge clk);
      res_n = 1'b1;
   endtask

   task automatic test_basic();
      int ek, dk;
      en = 1'b1;
      run_load(32'h0000_0512, ek, dk);
      tests++;
      if (ek !== 42 || dk !== 42) begin
         fails++;
         $display("FAIL basic_timing: got end=%0d done=%0d expected 42/42", ek, dk);
      end
      tests++;
      if (freq_bin !== 27'd512 || err !== 1'b0 || fout !== 1'b0) begin
         fails++;
         $display("FAIL basic_apply: got freq=%0d err=%b fout=%b expected 512/0/0", freq_bin, err, fout);
      end
      @(posedge clk);
      #1;
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse: got %b expected 0", done);
      end
   endtask

   // Bad digit while the 512 Hz setting runs; the first toggle must still
   // land exactly one half-period (39062 clk) after the earlier APPLY.
   task automatic test_bad_digit();
      int ek, dk, c0;
      c0 = a_cyc;
      run_load(32'h0000_A000, ek, dk);
      tests++;
      if (ek !== 5 || dk !== -1) begin
         fails++;
         $display("FAIL bad_digit_timing: got end=%0d done=%0d expected 5/-1", ek, dk);
      end
      tests++;
      if (err !== 1'b1 || freq_bin !== 27'd512) begin
         fails++;
         $display("FAIL bad_digit_state: got err=%b freq=%0d expected 1/512", err, freq_bin);
      end
      while (fout !== 1'b1 && (cyc - c0) < 50000) begin
         @(posedge clk);
         #1;
      end
      tests++;
      if ((cyc - c0) !== 39062) begin
         fails++;
         $display("FAIL half_512: got %0d expected 39062", cyc - c0);
      end
   endtask

   task automatic test_check_reject();
      int ek, dk;
      run_load(32'h2000_0001, ek, dk);
      tests++;
      if (ek !== 9 || dk !== -1 || err !== 1'b1 || freq_bin !== 27'd512) begin
         fails++;
         $display("FAIL too_big: got end=%0d done=%0d err=%b freq=%0d expected 9/-1/1/512",
                  ek, dk, err, freq_bin);
      end
      run_load(32'h2000_0000, ek, dk);
      tests++;
      if (ek !== 42 || dk !== 42 || err !== 1'b0 || freq_bin !== 27'd20_000_000) begin
         fails++;
         $display("FAIL max_freq: got end=%0d done=%0d err=%b freq=%0d expected 42/42/0/20000000",
                  ek, dk, err, freq_bin);
      end
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         tests++;
         if (fout !== logic'(i % 2)) begin
            fails++;
            $display("FAIL half_1 cycle %0d: got %b expected %0d", i, fout, i % 2);
         end
      end
   endtask

   task automatic test_zero();
      int ek, dk;
      bit  bad;
      run_load(32'h0000_0000, ek, dk);
      tests++;
      if (ek !== 10 || dk !== 10 || err !== 1'b0 || freq_bin !== 27'd0) begin
         fails++;
         $display("FAIL zero: got end=%0d done=%0d err=%b freq=%0d expected 10/10/0/0",
                  ek, dk, err, freq_bin);
      end
      bad = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (fout !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL zero_hold: got fout activity expected 0");
      end
      run_load(32'h0000_0001, ek, dk);
      tests++;
      if (ek !== 42 || dk !== 42 || freq_bin !== 27'd1) begin
         fails++;
         $display("FAIL one_hz: got end=%0d done=%0d freq=%0d expected 42/42/1", ek, dk, freq_bin);
      end
      repeat (100) begin
         @(posedge clk);
         #1;
         if (fout !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL one_hz_hold: got early toggle expected 0");
      end
   endtask

   // 5 MHz setting -> half-period 4; a second load at k=3 must be ignored.
   task automatic test_back_to_back();
      int k, ek, dk, m;
      @(negedge clk);
      bcd_in = 32'h0500_0000;
      load   = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      k    = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         k++;
      end
      @(negedge clk);
      bcd_in = 32'h0000_0003;
      load   = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      k++;
      ek = -1;
      dk = -1;
      while (k < 200) begin
         @(posedge clk);
         #1;
         k++;
         if (done === 1'b1 && dk < 0) dk = k;
         if (busy === 1'b0) begin
            ek = k;
            break;
         end
      end
      a_cyc = cyc;
      tests++;
      if (ek !== 42 || dk !== 42 || freq_bin !== 27'd5_000_000) begin
         fails++;
         $display("FAIL ignore_load: got end=%0d done=%0d freq=%0d expected 42/42/5000000",
                  ek, dk, freq_bin);
      end
      while (fout !== 1'b1 && (cyc - a_cyc) < 20) begin
         @(posedge clk);
         #1;
      end
      tests++;
      if ((cyc - a_cyc) !== 4 || busy !== 1'b0) begin
         fails++;
         $display("FAIL half_4: got %0d busy=%b expected 4/0", cyc - a_cyc, busy);
      end
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (fout !== 1'b0) begin
         fails++;
         $display("FAIL en_off: got %b expected 0", fout);
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      en = 1'b1;
      m  = 0;
      while (fout !== 1'b1 && m < 20) begin
         @(posedge clk);
         #1;
         m++;
      end
      tests++;
      if (m !== 4) begin
         fails++;
         $display("FAIL en_restart: got %0d expected 4", m);
      end
   endtask

   task automatic test_reset_mid_div();
      int  ek, dk;
      bit  bad;
      run_load(32'h0000_000F, ek, dk);
      tests++;
      if (ek !== 8 || err !== 1'b1) begin
         fails++;
         $display("FAIL bad_last_digit: got end=%0d err=%b expected 8/1", ek, err);
      end
      @(negedge clk);
      bcd_in = 32'h0000_0512;
      load   = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_in_div: got %b expected 1", busy);
      end
      #2;
      res_n = 1'b0;
      #1;
      tests++;
      if ({busy, done, err, fout} !== 4'b0000 || freq_bin !== 27'd0) begin
         fails++;
         $display("FAIL async_reset: got flags=%b freq=%0d expected 0000/0",
                  {busy, done, err, fout}, freq_bin);
      end
      @(negedge clk);
      res_n = 1'b1;
      bad   = 1'b0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0 || fout !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad || freq_bin !== 27'd0) begin
         fails++;
         $display("FAIL after_reset: got activity=%b freq=%0d expected 0/0", bad, freq_bin);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      a_cyc = 0;
      test_reset();
      test_basic();
      test_bad_digit();
      test_check_reject();
      test_zero();
      test_back_to_back();
      test_reset_mid_div();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
